// File: rtl/if_id_stage_pkg.sv
// Shared constants, IF/ID payload type and the PC increment helper for the fetch stage.
package if_id_stage_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_VECTOR = 32'h8000_0000;
    localparam logic [PC_W-1:0]    IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus4;
        logic               valid;
    } if_id_t;

    // Bit 31 is the kernel-mode flag; only the lower bits count and wrap.
    function automatic logic [PC_W-1:0] pc_increment(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1], pc[PC_W-2:0] + (PC_W-1)'(4)};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg
    import if_id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0] instr_id,
    output logic [PC_W-1:0]    pc_plus4_id,
    output logic               valid_id
);

    if_id_t q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= RESET_VECTOR;
            q.valid    <= 1'b0;
        end else if (flush) begin
            q.instr    <= NOP_INSTR;
            q.pc_plus4 <= pc_plus4;
            q.valid    <= 1'b0;
        end else if (load) begin
            q.instr    <= instr;
            q.pc_plus4 <= pc_plus4;
            q.valid    <= 1'b1;
        end
    end

    assign instr_id    = q.instr;
    assign pc_plus4_id = q.pc_plus4;
    assign valid_id    = q.valid;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC selection, IF/ID register and interrupt entry.
// Interrupt entry (irq_take, EPC, IRQ_Ack) exists only when IF_IRQ_EN is defined.
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_IFWrite,
    input  logic               Branch_Taken,
    input  logic [PC_W-1:0]    Branch_Target,
    input  logic               IRQ,
    input  logic [INSTR_W-1:0] Instr_in,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] Instr_id,
    output logic [PC_W-1:0]    PC_plus4_id,
    output logic               Valid_id,
    output logic               PC_31,
    output logic               PC_id_31,
    output logic               IRQ_Ack,
    output logic [PC_W-1:0]    EPC
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_incr_c;
    logic [PC_W-1:0] pc_next_c;
    logic            irq_take_c;
    logic            flush_c;

    assign pc_incr_c = pc_increment(pc_q);

`ifdef IF_IRQ_EN
    // Only user-mode code with a user-mode instruction in ID can be interrupted.
    assign irq_take_c = IRQ & ~pc_q[PC_W-1] & ~PC_plus4_id[PC_W-1];

    logic [PC_W-1:0] epc_q;
    logic            irq_ack_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q     <= '0;
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= irq_take_c;
            if (irq_take_c) begin
                epc_q <= Valid_id ? (PC_plus4_id - PC_W'(4)) : pc_q;
            end
        end
    end

    assign EPC     = epc_q;
    assign IRQ_Ack = irq_ack_q;
`else
    logic unused_irq;
    assign unused_irq = IRQ;
    assign irq_take_c = 1'b0;
    assign EPC        = '0;
    assign IRQ_Ack    = 1'b0;
`endif

    assign flush_c = irq_take_c | Branch_Taken;

    always_comb begin
        pc_next_c = pc_q;
        if (irq_take_c) begin
            pc_next_c = IRQ_VECTOR;
        end else if (Branch_Taken) begin
            pc_next_c = Branch_Target;
        end else if (PC_IFWrite) begin
            pc_next_c = pc_incr_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_next_c;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (PC_IFWrite),
        .flush       (flush_c),
        .instr       (Instr_in),
        .pc_plus4    (pc_incr_c),
        .instr_id    (Instr_id),
        .pc_plus4_id (PC_plus4_id),
        .valid_id    (Valid_id)
    );

    assign PC       = pc_q;
    assign PC_31    = pc_q[PC_W-1];
    assign PC_id_31 = PC_plus4_id[PC_W-1];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios then randomized traffic vs. a reference model.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        PC_IFWrite;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        IRQ;
    logic [31:0] Instr_in;
    logic [31:0] PC;
    logic [31:0] Instr_id;
    logic [31:0] PC_plus4_id;
    logic        Valid_id;
    logic        PC_31;
    logic        PC_id_31;
    logic        IRQ_Ack;
    logic [31:0] EPC;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_pp4, m_epc;
    logic        m_valid, m_ack;

    if_id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .PC_IFWrite    (PC_IFWrite),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .IRQ           (IRQ),
        .Instr_in      (Instr_in),
        .PC            (PC),
        .Instr_id      (Instr_id),
        .PC_plus4_id   (PC_plus4_id),
        .Valid_id      (Valid_id),
        .PC_31         (PC_31),
        .PC_id_31      (PC_id_31),
        .IRQ_Ack       (IRQ_Ack),
        .EPC           (EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Kernel bit is kept; the remaining 31 bits advance by 4 modulo 2^31.
    function automatic logic [31:0] next_seq(input logic [31:0] a);
        longint unsigned low;
        low = (longint'(a) % 64'h8000_0000 + 4) % 64'h8000_0000;
        return (a >= 32'h8000_0000) ? 32'(low + 64'h8000_0000) : 32'(low);
    endfunction

    task automatic model_step(input logic r, input logic wr, input logic br,
                              input logic [31:0] tgt, input logic irq, input logic [31:0] ins);
        logic        take;
        logic [31:0] seq;
        seq  = next_seq(m_pc);
`ifdef IF_IRQ_EN
        take = irq && (m_pc < 32'h8000_0000) && (m_pp4 < 32'h8000_0000);
`else
        take = 1'b0;
`endif
        if (r) begin
            m_pc = 32'h8000_0000; m_instr = 32'h0; m_pp4 = 32'h8000_0000;
            m_valid = 1'b0; m_ack = 1'b0; m_epc = 32'h0;
        end else begin
            m_ack = take;
            if (take) m_epc = m_valid ? m_pp4 - 32'd4 : m_pc;
            if (take || br) begin
                m_instr = 32'h0; m_valid = 1'b0; m_pp4 = seq;
                m_pc = take ? 32'h8000_0004 : tgt;
            end else if (wr) begin
                m_instr = ins; m_valid = 1'b1; m_pp4 = seq; m_pc = seq;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".PC"},          PC,                  m_pc);
        check({ctx, ".Instr_id"},    Instr_id,            m_instr);
        check({ctx, ".PC_plus4_id"}, PC_plus4_id,         m_pp4);
        check({ctx, ".Valid_id"},    32'(Valid_id),       32'(m_valid));
        check({ctx, ".PC_31"},       32'(PC_31),          32'(m_pc[31]));
        check({ctx, ".PC_id_31"},    32'(PC_id_31),       32'(m_pp4[31]));
        check({ctx, ".IRQ_Ack"},     32'(IRQ_Ack),        32'(m_ack));
        check({ctx, ".EPC"},         EPC,                 m_epc);
    endtask

    task automatic step(input string ctx, input logic r, input logic wr, input logic br,
                        input logic [31:0] tgt, input logic irq, input logic [31:0] ins);
        @(negedge clk);
        reset = r; PC_IFWrite = wr; Branch_Taken = br;
        Branch_Target = tgt; IRQ = irq; Instr_in = ins;
        model_step(r, wr, br, tgt, irq, ins);
        @(posedge clk);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        reset = 1'b1; PC_IFWrite = 1'b0; Branch_Taken = 1'b0;
        Branch_Target = '0; IRQ = 1'b0; Instr_in = '0;
        m_pc = '0; m_instr = '0; m_pp4 = '0; m_epc = '0; m_valid = 1'b0; m_ack = 1'b0;

        // Reset, including with other inputs active
        step("rst0", 1, 1, 1, 32'h0000_1234, 1, 32'hDEAD_BEEF);
        step("rst1", 1, 0, 0, 32'h0, 0, 32'h0);
        check("rst.PC", PC, 32'h8000_0000);
        check("rst.PC_plus4_id", PC_plus4_id, 32'h8000_0000);

        // First fetch after reset
        step("first", 0, 1, 0, 32'h0, 0, 32'h2001_0005);
        check("first.PC", PC, 32'h8000_0004);
        check("first.Instr_id", Instr_id, 32'h2001_0005);
        check("first.PC_plus4_id", PC_plus4_id, 32'h8000_0004);
        check("first.Valid_id", 32'(Valid_id), 32'd1);

        // Stall for two cycles at 0x100, then release
        step("br100", 0, 1, 1, 32'h0000_0100, 0, 32'h1111_1111);
        step("stall1", 0, 0, 0, 32'h0, 0, 32'h2222_2222);
        step("stall2", 0, 0, 0, 32'h0, 0, 32'h3333_3333);
        check("stall.PC", PC, 32'h0000_0100);
        step("release", 0, 1, 0, 32'h0, 0, 32'h4444_4444);
        check("release.PC", PC, 32'h0000_0104);

        // Branch dominates a simultaneous stall
        step("brstall", 0, 0, 1, 32'h0000_0040, 0, 32'h5555_5555);
        check("brstall.PC", PC, 32'h0000_0040);
        check("brstall.Instr_id", Instr_id, 32'h0);
        check("brstall.Valid_id", 32'(Valid_id), 32'd0);

        // Increment wraps bits 30:0 and keeps bit 31 clear
        step("brwrap", 0, 1, 1, 32'h7FFF_FFFC, 0, 32'h0);
        step("wrap", 0, 1, 0, 32'h0, 0, 32'h6666_6666);
        check("wrap.PC", PC, 32'h0000_0000);

`ifdef IF_IRQ_EN
        // Interrupt wins over branch, EPC points at the instruction in ID
        step("br1fc", 0, 1, 1, 32'h0000_01FC, 0, 32'h0);
        step("to200", 0, 1, 0, 32'h0, 0, 32'h7777_7777);
        step("irq", 0, 1, 1, 32'h0000_0ABC, 1, 32'h8888_8888);
        check("irq.PC", PC, 32'h8000_0004);
        check("irq.EPC", EPC, 32'h0000_01FC);
        check("irq.IRQ_Ack", 32'(IRQ_Ack), 32'd1);
        step("irqhold", 0, 1, 0, 32'h0, 1, 32'h9999_9999);
        check("irqhold.IRQ_Ack", 32'(IRQ_Ack), 32'd0);
        check("irqhold.PC", PC, 32'h8000_0008);
`endif

        // Kernel-mode fetch ignores IRQ
        step("rstk", 1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step("kseq", 0, 1, 0, 32'h0, 0, 32'h1000_0000 + 32'(i));
        step("kirq", 0, 1, 0, 32'h0, 1, 32'hAAAA_AAAA);
        check("kirq.PC", PC, 32'h8000_0014);
        check("kirq.IRQ_Ack", 32'(IRQ_Ack), 32'd0);

        // Reset during a stall in user space
        step("br300", 0, 1, 1, 32'h0000_0300, 0, 32'h0);
        step("st300", 0, 0, 0, 32'h0, 0, 32'h0);
        step("rststall", 1, 0, 0, 32'h0, 1, 32'hBBBB_BBBB);
        check("rststall.PC", PC, 32'h8000_0000);
        check("rststall.Valid_id", 32'(Valid_id), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r, wr, br, irq;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2);
            wr  = ($urandom_range(0, 99) >= 20);
            br  = ($urandom_range(0, 99) < 15);
            irq = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
                0:       tgt = 32'h7FFF_FFF8;
                1:       tgt = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
                default: tgt = $urandom & 32'h0000_0FFC;
            endcase
            step("rand", r, wr, br, tgt, irq, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
